// File: rtl/rob_superscalar_if.sv
// Port bundle for the superscalar ROB: dispatch, completion bus, operand lookup, retire, squash and status.
// The master side is the core (dispatch/CDB/lookup/squash driver); the slave side is the ROB itself.
interface rob_superscalar_if #(
  parameter int ROB_DEPTH = 16,
  parameter int DP_WIDTH  = 2,
  parameter int CDB_WIDTH = 2,
  parameter int RT_WIDTH  = 2,
  parameter int RD_PORTS  = 4,
  parameter int DATA_W    = 32,
  parameter int REG_W     = 5
);
  localparam int TAG_W = $clog2(ROB_DEPTH);

  logic [DP_WIDTH-1:0]                  dp_valid;
  logic [DP_WIDTH-1:0]                  dp_has_dest;
  logic [DP_WIDTH-1:0][REG_W-1:0]       dp_dest_reg;
  logic [DP_WIDTH-1:0]                  dp_is_store;
  logic                                 dp_ready;
  logic [DP_WIDTH-1:0][TAG_W-1:0]       dp_tag;
  logic [TAG_W:0]                       free_slots;

  logic [CDB_WIDTH-1:0]                 cdb_valid;
  logic [CDB_WIDTH-1:0][TAG_W-1:0]      cdb_tag;
  logic [CDB_WIDTH-1:0][DATA_W-1:0]     cdb_value;

  logic [RD_PORTS-1:0][TAG_W-1:0]       rd_tag;
  logic [RD_PORTS-1:0]                  rd_ready;
  logic [RD_PORTS-1:0][DATA_W-1:0]      rd_value;

  logic [RT_WIDTH-1:0]                  rt_valid;
  logic [RT_WIDTH-1:0][TAG_W-1:0]       rt_tag;
  logic [RT_WIDTH-1:0][REG_W-1:0]       rt_dest_reg;
  logic [RT_WIDTH-1:0]                  rt_has_dest;
  logic [RT_WIDTH-1:0]                  rt_is_store;
  logic [RT_WIDTH-1:0][DATA_W-1:0]      rt_value;

  logic                                 squash_valid;
  logic [TAG_W-1:0]                     squash_tag;
  logic                                 empty;
  logic                                 full;

  modport master (
    output dp_valid, dp_has_dest, dp_dest_reg, dp_is_store, cdb_valid, cdb_tag, cdb_value,
           rd_tag, squash_valid, squash_tag,
    input  dp_ready, dp_tag, free_slots, rd_ready, rd_value, rt_valid, rt_tag, rt_dest_reg,
           rt_has_dest, rt_is_store, rt_value, empty, full
  );

  modport slave (
    input  dp_valid, dp_has_dest, dp_dest_reg, dp_is_store, cdb_valid, cdb_tag, cdb_value,
           rd_tag, squash_valid, squash_tag,
    output dp_ready, dp_tag, free_slots, rd_ready, rd_value, rt_valid, rt_tag, rt_dest_reg,
           rt_has_dest, rt_is_store, rt_value, empty, full
  );
endinterface

// File: rtl/rob_superscalar.sv
// N-wide reorder buffer: in-order allocate, CDB complete, 0-cycle operand lookup with CDB bypass, in-order retire (rt_* registered).
// Dispatch is all-or-nothing and blocked while dp_ready=0 or squashing; requester holds its lanes until accepted.
module rob_superscalar #(
  parameter int ROB_DEPTH = 16,
  parameter int DP_WIDTH  = 2,
  parameter int CDB_WIDTH = 2,
  parameter int RT_WIDTH  = 2,
  parameter int RD_PORTS  = 4,
  parameter int DATA_W    = 32,
  parameter int REG_W     = 5
) (
  input logic               clock,
  input logic               reset,
  rob_superscalar_if.slave  bus
);
  localparam int TAG_W = $clog2(ROB_DEPTH);
  typedef logic [TAG_W-1:0] tag_t;
  typedef logic [TAG_W:0]   cnt_t;

  typedef struct packed {
    logic              valid;
    logic              complete;
    logic              has_dest;
    logic [REG_W-1:0]  dest_reg;
    logic              is_store;
    logic [DATA_W-1:0] value;
  } entry_t;

  entry_t                rob [ROB_DEPTH];
  tag_t                  head, tail;
  cnt_t                  count;
  cnt_t                  n_dp, n_ret;
  logic                  dp_fire;
  logic [RT_WIDTH-1:0]   ret;
  logic [ROB_DEPTH-1:0]  squashed;
  tag_t                  sq_dist;

  assign bus.free_slots = cnt_t'(ROB_DEPTH) - count;
  assign bus.dp_ready   = bus.free_slots >= cnt_t'(DP_WIDTH);
  assign bus.empty      = (count == '0);
  assign bus.full       = (count == cnt_t'(ROB_DEPTH));
  assign dp_fire        = bus.dp_ready && !bus.squash_valid;
  assign sq_dist        = bus.squash_tag - head;

  always_comb begin
    n_dp = '0;
    for (int i = 0; i < DP_WIDTH; i++) begin
      bus.dp_tag[i] = tail + tag_t'(i);
      if (dp_fire && bus.dp_valid[i]) n_dp = n_dp + cnt_t'(1);
    end
  end

  // Age is measured as distance from head, so wrap needs no special casing.
  always_comb begin
    for (int j = 0; j < ROB_DEPTH; j++)
      squashed[j] = bus.squash_valid && ((tag_t'(j) - head) > sq_dist);
  end

  always_comb begin : retire_sel
    tag_t idx;
    logic go;
    ret   = '0;
    n_ret = '0;
    go    = 1'b1;
    idx   = head;
    for (int k = 0; k < RT_WIDTH; k++) begin
      idx = head + tag_t'(k);
      if (go && rob[idx].valid && rob[idx].complete && !squashed[idx] &&
          (!rob[idx].is_store || k == 0)) begin
        ret[k] = 1'b1;
        n_ret  = n_ret + cnt_t'(1);
        go     = !rob[idx].is_store;
      end else begin
        go = 1'b0;
      end
    end
  end

  always_comb begin : lookup
    entry_t            e;
    logic              byp;
    logic [DATA_W-1:0] bval;
    for (int p = 0; p < RD_PORTS; p++) begin
      e    = rob[bus.rd_tag[p]];
      byp  = 1'b0;
      bval = '0;
      for (int c = CDB_WIDTH - 1; c >= 0; c--) begin
        if (bus.cdb_valid[c] && bus.cdb_tag[c] == bus.rd_tag[p]) begin
          byp  = 1'b1;
          bval = bus.cdb_value[c];
        end
      end
      bus.rd_ready[p] = e.valid && (e.complete || byp);
      bus.rd_value[p] = !e.valid ? '0 : byp ? bval : e.complete ? e.value : '0;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
      for (int j = 0; j < ROB_DEPTH; j++) rob[j] <= '0;
      bus.rt_valid    <= '0;
      bus.rt_tag      <= '0;
      bus.rt_dest_reg <= '0;
      bus.rt_has_dest <= '0;
      bus.rt_is_store <= '0;
      bus.rt_value    <= '0;
    end else begin
      // Descending order so the lowest channel's write lands last.
      for (int c = CDB_WIDTH - 1; c >= 0; c--) begin
        if (bus.cdb_valid[c] && rob[bus.cdb_tag[c]].valid && !squashed[bus.cdb_tag[c]]) begin
          rob[bus.cdb_tag[c]].complete <= 1'b1;
          rob[bus.cdb_tag[c]].value    <= bus.cdb_value[c];
        end
      end
      for (int i = 0; i < DP_WIDTH; i++) begin
        if (dp_fire && bus.dp_valid[i])
          rob[tail + tag_t'(i)] <= '{valid: 1'b1, complete: 1'b0, has_dest: bus.dp_has_dest[i],
                                     dest_reg: bus.dp_dest_reg[i], is_store: bus.dp_is_store[i],
                                     value: '0};
      end
      for (int j = 0; j < ROB_DEPTH; j++)
        if (squashed[j]) rob[j] <= '0;
      for (int k = 0; k < RT_WIDTH; k++) begin
        if (ret[k]) rob[head + tag_t'(k)] <= '0;
        bus.rt_tag[k]      <= ret[k] ? head + tag_t'(k) : '0;
        bus.rt_dest_reg[k] <= ret[k] ? rob[head + tag_t'(k)].dest_reg : '0;
        bus.rt_has_dest[k] <= ret[k] && rob[head + tag_t'(k)].has_dest;
        bus.rt_is_store[k] <= ret[k] && rob[head + tag_t'(k)].is_store;
        bus.rt_value[k]    <= ret[k] ? rob[head + tag_t'(k)].value : '0;
      end
      bus.rt_valid <= ret;
      head <= head + n_ret[TAG_W-1:0];
      if (bus.squash_valid) begin
        tail  <= bus.squash_tag + tag_t'(1);
        count <= cnt_t'(sq_dist) + cnt_t'(1) - n_ret;
      end else begin
        tail  <= tail + n_dp[TAG_W-1:0];
        count <= count + n_dp - n_ret;
      end
    end
  end

  always @(posedge clock) begin
    if (reset) begin
      for (int a = 0; a < CDB_WIDTH; a++)
        for (int b = a + 1; b < CDB_WIDTH; b++)
          assert (!(bus.cdb_valid[a] && bus.cdb_valid[b] && bus.cdb_tag[a] == bus.cdb_tag[b]));
      assert (!bus.squash_valid || rob[bus.squash_tag].valid);
    end
  end
endmodule

// File: tb/tb_rob_superscalar.sv
// Bench for rob_superscalar: directed scenarios then random traffic, all checked against an in-order queue model.
module tb_rob_superscalar;
  logic clock = 1'b0;
  logic reset = 1'b0;
  int   tests = 0;
  int   fails = 0;

  always #5 clock = ~clock;

  rob_superscalar_if #(.ROB_DEPTH(16), .DP_WIDTH(2), .CDB_WIDTH(2), .RT_WIDTH(2),
                       .RD_PORTS(4), .DATA_W(32), .REG_W(5)) bus ();

  rob_superscalar #(.ROB_DEPTH(16), .DP_WIDTH(2), .CDB_WIDTH(2), .RT_WIDTH(2),
                    .RD_PORTS(4), .DATA_W(32), .REG_W(5)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    int          tag;
    bit          comp;
    bit          hd;
    logic [4:0]  dr;
    bit          st;
    logic [31:0] val;
  } ment_t;

  ment_t       q[$];
  int          hd_tag;
  bit   [1:0]  e_rt_v;
  int          e_rt_tag [2];
  bit          e_rt_hd  [2];
  bit          e_rt_st  [2];
  logic [4:0]  e_rt_dr  [2];
  logic [31:0] e_rt_val [2];

  task automatic check(input string name, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
    end
  endtask

  function automatic int find(input int t);
    for (int i = 0; i < q.size(); i++) if (q[i].tag == t) return i;
    return -1;
  endfunction

  task automatic model_reset();
    q.delete();
    hd_tag = 0;
    e_rt_v = '0;
    for (int k = 0; k < 2; k++) begin
      e_rt_tag[k] = 0; e_rt_hd[k] = 0; e_rt_st[k] = 0; e_rt_dr[k] = '0; e_rt_val[k] = '0;
    end
  endtask

  task automatic model_step();
    int lim, n, tail_tag, idx;
    bit ready;
    ment_t e;
    if (!reset) begin
      model_reset();
      return;
    end
    ready    = (16 - q.size()) >= 2;
    tail_tag = (hd_tag + q.size()) % 16;
    lim      = q.size();
    if (bus.squash_valid) lim = find(int'(bus.squash_tag)) + 1;
    n = 0;
    e_rt_v = '0;
    for (int k = 0; k < 2; k++) begin
      if (k >= lim || !q[k].comp || (q[k].st && k > 0)) break;
      e_rt_v[k] = 1'b1;
      e_rt_tag[k] = q[k].tag; e_rt_hd[k] = q[k].hd; e_rt_st[k] = q[k].st;
      e_rt_dr[k] = q[k].dr; e_rt_val[k] = q[k].val;
      n++;
      if (q[k].st) break;
    end
    while (q.size() > lim) void'(q.pop_back());
    for (int c = 1; c >= 0; c--) begin
      idx = find(int'(bus.cdb_tag[c]));
      if (bus.cdb_valid[c] && idx >= 0) begin
        q[idx].comp = 1'b1;
        q[idx].val  = bus.cdb_value[c];
      end
    end
    repeat (n) void'(q.pop_front());
    hd_tag = (hd_tag + n) % 16;
    if (!bus.squash_valid && ready) begin
      for (int i = 0; i < 2; i++) begin
        if (bus.dp_valid[i]) begin
          e.tag = (tail_tag + i) % 16; e.comp = 0; e.hd = bus.dp_has_dest[i];
          e.dr = bus.dp_dest_reg[i]; e.st = bus.dp_is_store[i]; e.val = '0;
          q.push_back(e);
        end
      end
    end
  endtask

  task automatic check_outputs();
    int fs, idx;
    bit er, hit;
    logic [31:0] ev;
    fs = 16 - q.size();
    check("free_slots", 64'(bus.free_slots), 64'(fs));
    check("dp_ready", 64'(bus.dp_ready), 64'(fs >= 2));
    check("empty", 64'(bus.empty), 64'(q.size() == 0));
    check("full", 64'(bus.full), 64'(q.size() == 16));
    for (int i = 0; i < 2; i++)
      check("dp_tag", 64'(bus.dp_tag[i]), 64'((hd_tag + q.size() + i) % 16));
    for (int p = 0; p < 4; p++) begin
      idx = find(int'(bus.rd_tag[p]));
      er = 0; ev = '0; hit = 0;
      if (idx >= 0) begin
        for (int c = 0; c < 2; c++) begin
          if (!hit && bus.cdb_valid[c] && bus.cdb_tag[c] == bus.rd_tag[p]) begin
            hit = 1; er = 1; ev = bus.cdb_value[c];
          end
        end
        if (!hit && q[idx].comp) begin
          er = 1; ev = q[idx].val;
        end
      end
      check("rd_ready", 64'(bus.rd_ready[p]), 64'(er));
      check("rd_value", 64'(bus.rd_value[p]), 64'(ev));
    end
    check("rt_valid", 64'(bus.rt_valid), 64'(e_rt_v));
    for (int k = 0; k < 2; k++) begin
      if (e_rt_v[k]) begin
        check("rt_tag", 64'(bus.rt_tag[k]), 64'(e_rt_tag[k]));
        check("rt_dest_reg", 64'(bus.rt_dest_reg[k]), 64'(e_rt_dr[k]));
        check("rt_has_dest", 64'(bus.rt_has_dest[k]), 64'(e_rt_hd[k]));
        check("rt_is_store", 64'(bus.rt_is_store[k]), 64'(e_rt_st[k]));
        check("rt_value", 64'(bus.rt_value[k]), 64'(e_rt_val[k]));
      end
    end
  endtask

  task automatic step();
    #1;
    check_outputs();
    @(posedge clock);
    model_step();
    @(negedge clock);
  endtask

  task automatic idle();
    bus.dp_valid = '0; bus.dp_has_dest = '0; bus.dp_dest_reg = '0; bus.dp_is_store = '0;
    bus.cdb_valid = '0; bus.cdb_tag = '0; bus.cdb_value = '0;
    bus.squash_valid = 1'b0; bus.squash_tag = '0;
    for (int p = 0; p < 4; p++) bus.rd_tag[p] = 4'($urandom_range(15));
  endtask

  task automatic drv_dp(input logic [1:0] v, input logic [1:0] st);
    bus.dp_valid = v;
    bus.dp_is_store = st;
    bus.dp_has_dest = 2'($urandom_range(3));
    for (int i = 0; i < 2; i++) bus.dp_dest_reg[i] = 5'($urandom_range(31));
  endtask

  task automatic drv_cdb(input int ch, input int tag, input logic [31:0] val);
    bus.cdb_valid[ch] = 1'b1;
    bus.cdb_tag[ch]   = 4'(tag);
    bus.cdb_value[ch] = val;
  endtask

  initial begin
    int r, t;
    idle();
    repeat (2) @(posedge clock);
    model_reset();
    @(negedge clock);
    #1;
    check("reset_rt_valid", 64'(bus.rt_valid), 64'(0));
    check("reset_rt_tag", 64'(bus.rt_tag), 64'(0));
    check("reset_rt_value", 64'(bus.rt_value), 64'(0));
    check("reset_free", 64'(bus.free_slots), 64'(16));
    check("reset_dp_ready", 64'(bus.dp_ready), 64'(1));
    check("reset_empty", 64'(bus.empty), 64'(1));
    check("reset_full", 64'(bus.full), 64'(0));
    reset = 1'b1;

    // Eight ops in four 2-lane dispatches, nothing completes.
    for (int j = 0; j < 4; j++) begin
      idle(); drv_dp(2'b11, 2'b00);
      #1;
      check("disp_tag0", 64'(bus.dp_tag[0]), 64'(2 * j));
      check("disp_tag1", 64'(bus.dp_tag[1]), 64'(2 * j + 1));
      step();
    end
    idle(); #1;
    check("free_after_8", 64'(bus.free_slots), 64'(8));
    check("no_retire", 64'(bus.rt_valid), 64'(0));

    // Tags 1 and 0 complete together, retire two edges later.
    drv_cdb(0, 1, 32'h1111_0001); drv_cdb(1, 0, 32'h2222_0000);
    step();
    idle(); step();
    #1;
    check("pair_rt_valid", 64'(bus.rt_valid), 64'(2'b11));
    check("pair_rt_tag", 64'(bus.rt_tag), 64'(8'h10));
    check("pair_val0", 64'(bus.rt_value[0]), 64'(32'h2222_0000));
    check("pair_val1", 64'(bus.rt_value[1]), 64'(32'h1111_0001));

    // Fill to 16, hold, then free two slots; the wrapped tail hands out 2,3.
    for (int j = 0; j < 5; j++) begin
      idle(); drv_dp(2'b11, 2'b00); step();
    end
    idle(); drv_dp(2'b11, 2'b00); #1;
    check("fill_full", 64'(bus.full), 64'(1));
    check("fill_dp_ready", 64'(bus.dp_ready), 64'(0));
    step();
    #1;
    check("held_free", 64'(bus.free_slots), 64'(0));
    drv_cdb(0, 2, 32'hA2); drv_cdb(1, 3, 32'hA3);
    step();
    #1;
    check("retire_edge_ready", 64'(bus.dp_ready), 64'(0));
    step();
    idle(); drv_dp(2'b11, 2'b00); #1;
    check("wrap_ready", 64'(bus.dp_ready), 64'(1));
    check("wrap_tag0", 64'(bus.dp_tag[0]), 64'(2));
    check("wrap_tag1", 64'(bus.dp_tag[1]), 64'(3));
    step();

    // Store at head retires alone in lane 0; the ALU op follows next cycle.
    reset = 1'b0; idle(); step(); reset = 1'b1;
    idle(); drv_dp(2'b11, 2'b01); step();
    idle(); drv_cdb(0, 0, 32'h5700_0000); drv_cdb(1, 1, 32'hA1A1_0001); step();
    idle(); step();
    #1;
    check("store_rt_valid", 64'(bus.rt_valid), 64'(2'b01));
    check("store_rt_is_store", 64'(bus.rt_is_store[0]), 64'(1));
    check("store_rt_tag", 64'(bus.rt_tag[0]), 64'(0));
    idle(); step();
    #1;
    check("alu_rt_valid", 64'(bus.rt_valid), 64'(2'b01));
    check("alu_rt_tag", 64'(bus.rt_tag[0]), 64'(1));
    check("alu_rt_value", 64'(bus.rt_value[0]), 64'(32'hA1A1_0001));

    // Walk head to 12, load 10 entries, then squash to 14 with competing dispatch and CDB.
    for (int j = 0; j < 5; j++) begin
      idle(); drv_dp(2'b11, 2'b00); step();
    end
    for (int j = 0; j < 5; j++) begin
      idle(); drv_cdb(0, 2 + 2 * j, 32'(j)); drv_cdb(1, 3 + 2 * j, 32'(j + 100)); step();
    end
    idle(); step();
    idle(); step();
    idle(); #1;
    check("head12_empty", 64'(bus.empty), 64'(1));
    check("head12_tag", 64'(bus.dp_tag[0]), 64'(12));
    for (int j = 0; j < 5; j++) begin
      idle(); drv_dp(2'b11, 2'b00); step();
    end
    idle(); drv_dp(2'b11, 2'b00);
    bus.squash_valid = 1'b1; bus.squash_tag = 4'd14;
    drv_cdb(0, 2, 32'hCAFE_F00D);
    step();
    idle(); bus.rd_tag[0] = 4'd2; #1;
    check("squash_free", 64'(bus.free_slots), 64'(13));
    check("squash_tail", 64'(bus.dp_tag[0]), 64'(15));
    check("squash_tag2_gone", 64'(bus.rd_ready[0]), 64'(0));

    // Same-cycle CDB bypass on a lookup.
    idle(); bus.rd_tag[0] = 4'd13; drv_cdb(1, 13, 32'hDEAD_BEEF); #1;
    check("bypass_ready", 64'(bus.rd_ready[0]), 64'(1));
    check("bypass_value", 64'(bus.rd_value[0]), 64'(32'hDEAD_BEEF));
    step();

    // Random traffic, including a mid-run reset.
    reset = 1'b0; idle(); step(); reset = 1'b1;
    for (int cyc = 0; cyc < 600; cyc++) begin
      idle();
      if (cyc == 300) reset = 1'b0;
      if (cyc == 301) reset = 1'b1;
      if (q.size() > 0 && $urandom_range(15) == 0) begin
        bus.squash_valid = 1'b1;
        bus.squash_tag = 4'(q[$urandom_range(q.size() - 1)].tag);
      end
      r = $urandom_range(3);
      drv_dp(r == 0 ? 2'b00 : (r == 1 ? 2'b01 : 2'b11),
             {1'($urandom_range(3) == 0), 1'($urandom_range(3) == 0)});
      for (int c = 0; c < 2; c++) begin
        if ($urandom_range(2) != 0) begin
          t = (q.size() > 0 && $urandom_range(3) != 0) ? q[$urandom_range(q.size() - 1)].tag
                                                       : int'($urandom_range(15));
          if (!(c == 1 && bus.cdb_valid[0] && int'(bus.cdb_tag[0]) == t))
            drv_cdb(c, t, $urandom);
        end
      end
      step();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
